sid_write_arb: RTL and testbench

Write arbiter and pacing queue for the SID register port. Two independent requesters (host CPU bus and the tune-player sequencer) submit register writes; the block arbitrates between them round-robin, buffers accepted writes in a FIFO, and replays them into the `sid` module's `iWE`/`iAddr`/`iDataW` port at no more than one write per `clkEn` tick. Writes reach the SID in order and at C64-like bus pacing, regardless of requester burstiness.

---
 rtl/sid_write_arb.sv | 130 +++++++++++++
 tb/tb_sid_write_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_write_arb.sv
// Round-robin write arbiter and FIFO pacing queue for the SID register port.
// Two requesters enqueue writes; the queue drains at most one write per clkEn tick.
`timescale 1ns / 1ps
module sid_write_arb #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clkEn,
  input  logic             iFlush,
  input  logic             iReqA,
  input  logic [4:0]       iAddrA,
  input  logic [7:0]       iDataA,
  output logic             oAckA,
  input  logic             iReqB,
  input  logic [4:0]       iAddrB,
  input  logic [7:0]       iDataB,
  output logic             oAckB,
  output logic             oWE,
  output logic [4:0]       oAddr,
  output logic [7:0]       oDataW,
  output logic [LVL_W-1:0] oLevel,
  output logic             oFull,
  output logic             oEmpty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [12:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             last_grant_q, last_grant_d;
  logic             we_q;
  logic [4:0]       addr_q;
  logic [7:0]       data_q;

  logic             can_accept;
  logic             grant_a, grant_b;
  logic             accept;
  logic             pop;
  logic [12:0]      wr_entry;

  assign oFull  = (level_q == LVL_W'(DEPTH));
  assign oEmpty = (level_q == '0);
  assign oLevel = level_q;
  assign oWE    = we_q;
  assign oAddr  = addr_q;
  assign oDataW = data_q;

  // rstn gates the acks so nothing looks accepted while the block is held in reset.
  assign can_accept = rstn && !oFull && !iFlush;

  // On a tie the requester that did not win last time is served.
  assign grant_a = iReqA && (!iReqB || last_grant_q);
  assign grant_b = iReqB && (!iReqA || !last_grant_q);

  assign oAckA  = can_accept && grant_a;
  assign oAckB  = can_accept && grant_b;
  assign accept = oAckA || oAckB;
  assign pop    = clkEn && !oEmpty && !iFlush;

  always_comb begin
    wr_entry = {iAddrB, iDataB};
    if (oAckA) begin
      wr_entry = {iAddrA, iDataA};
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    last_grant_d = last_grant_q;
    if (iFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (accept) begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        last_grant_d = oAckB;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({accept, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Storage needs no reset; level and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        {addr_q, data_q} <= mem[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_sid_write_arb.sv
// Scoreboard bench for sid_write_arb: expected writes are queued at issue time and
// a monitor checks each oWE pulse against the queue head.
`timescale 1ns / 1ps
module tb_sid_write_arb;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clkEn;
  logic       iFlush;
  logic       iReqA, iReqB;
  logic [4:0] iAddrA, iAddrB;
  logic [7:0] iDataA, iDataB;
  logic       oAckA, oAckB;
  logic       oWE;
  logic [4:0] oAddr;
  logic [7:0] oDataW;
  logic [3:0] oLevel;
  logic       oFull, oEmpty;

  logic       man_en = 1'b0;
  logic       auto_en = 1'b0;
  logic       auto_pulse = 1'b0;
  int         auto_cnt = 0;
  logic       spacing_en = 1'b0;
  logic       have_prev = 1'b0;
  time        prev_t = 0;

  int         checks = 0;
  int         errors = 0;
  int         wr_count = 0;
  logic [12:0] exp_q[$];

  sid_write_arb #(.DEPTH(8), .LVL_W(4)) dut (
    .clk(clk), .rstn(rstn), .clkEn(clkEn), .iFlush(iFlush),
    .iReqA(iReqA), .iAddrA(iAddrA), .iDataA(iDataA), .oAckA(oAckA),
    .iReqB(iReqB), .iAddrB(iAddrB), .iDataB(iDataB), .oAckB(oAckB),
    .oWE(oWE), .oAddr(oAddr), .oDataW(oDataW),
    .oLevel(oLevel), .oFull(oFull), .oEmpty(oEmpty)
  );

  always #5 clk = ~clk;

  assign clkEn = auto_en ? auto_pulse : man_en;

  // One-cycle clkEn strobe every 16 clk cycles when auto mode is on.
  always @(negedge clk) begin
    if (auto_en) begin
      auto_pulse = (auto_cnt == 15);
      auto_cnt   = (auto_cnt + 1) % 16;
    end else begin
      auto_pulse = 1'b0;
      auto_cnt   = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [12:0] head;
    if (!spacing_en) have_prev = 1'b0;
    if (oWE === 1'b1) begin
      wr_count++;
      if (spacing_en) begin
        if (have_prev) chk("we_spacing", 32'($time - prev_t), 32'd160);
        prev_t    = $time;
        have_prev = 1'b1;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", oAddr, oDataW);
      end else begin
        head = exp_q.pop_front();
        chk("write_order", 32'({oAddr, oDataW}), 32'(head));
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic pulse_en(input int n);
    for (int k = 0; k < n; k++) begin
      man_en = 1'b1;
      @(negedge clk);
      man_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic enq_a(input logic [4:0] a, input logic [7:0] d, input logic push);
    iReqA = 1'b1; iAddrA = a; iDataA = d;
    #1;
    chk("enq_ack_a", 32'(oAckA), 32'd1);
    if (push) exp_q.push_back({a, d});
    @(negedge clk);
    iReqA = 1'b0;
  endtask

  task automatic enq_b(input logic [4:0] a, input logic [7:0] d, input logic push);
    iReqB = 1'b1; iAddrB = a; iDataB = d;
    #1;
    chk("enq_ack_b", 32'(oAckB), 32'd1);
    if (push) exp_q.push_back({a, d});
    @(negedge clk);
    iReqB = 1'b0;
  endtask

  initial begin
    int ia, ib, cyc, base;
    rstn = 1'b1; iFlush = 1'b0;
    iReqA = 1'b0; iAddrA = '0; iDataA = '0;
    iReqB = 1'b0; iAddrB = '0; iDataB = '0;
    #1 rstn = 1'b0;
    iReqA = 1'b1;
    #2;
    chk("rst_we", 32'(oWE), 32'd0);
    chk("rst_level", 32'(oLevel), 32'd0);
    chk("rst_empty", 32'(oEmpty), 32'd1);
    chk("rst_full", 32'(oFull), 32'd0);
    chk("rst_ack_a", 32'(oAckA), 32'd0);
    chk("rst_addr", 32'({oAddr, oDataW}), 32'd0);
    iReqA = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Round-robin: A wins first tie, then alternates; pulses 16 clk apart.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({5'(8 + i), 8'(8'hA0 + i)});
      exp_q.push_back({5'(12 + i), 8'(8'hB0 + i)});
    end
    auto_en = 1'b1;
    spacing_en = 1'b1;
    ia = 0; ib = 0; cyc = 0;
    while ((ia < 4 || ib < 4) && cyc < 50) begin
      iReqA = (ia < 4); iAddrA = 5'(8 + ia); iDataA = 8'(8'hA0 + ia);
      iReqB = (ib < 4); iAddrB = 5'(12 + ib); iDataB = 8'(8'hB0 + ib);
      #1;
      chk("rr_ack_a", 32'(oAckA), 32'((cyc % 2) == 0));
      chk("rr_ack_b", 32'(oAckB), 32'((cyc % 2) == 1));
      if (oAckA) ia++;
      if (oAckB) ib++;
      @(negedge clk);
      cyc++;
    end
    iReqA = 1'b0; iReqB = 1'b0;
    for (int k = 0; k < 400 && wr_count < 8; k++) @(negedge clk);
    chk("rr_writes", 32'(wr_count), 32'd8);
    spacing_en = 1'b0;
    auto_en = 1'b0;
    @(negedge clk);

    // Single write: ack same cycle, one oWE after the next clkEn edge.
    enq_a(5'h18, 8'h1F, 1'b1);
    #1;
    chk("single_level", 32'(oLevel), 32'd1);
    chk("single_we_idle", 32'(oWE), 32'd0);
    @(negedge clk);
    man_en = 1'b1;
    @(negedge clk);
    man_en = 1'b0;
    #1;
    chk("single_we", 32'(oWE), 32'd1);
    chk("single_out", 32'({oAddr, oDataW}), 32'h181F);
    chk("single_level0", 32'(oLevel), 32'd0);
    @(negedge clk);
    #1;
    chk("single_we_low", 32'(oWE), 32'd0);
    chk("single_hold", 32'({oAddr, oDataW}), 32'h181F);
    @(negedge clk);

    // Full boundary with clkEn low.
    for (int i = 0; i < 8; i++) enq_b(5'(i), 8'(8'h40 + i), 1'b1);
    iReqB = 1'b1; iAddrB = 5'd8; iDataB = 8'h48;
    #1;
    chk("full_flag", 32'(oFull), 32'd1);
    chk("full_level", 32'(oLevel), 32'd8);
    chk("full_no_ack", 32'(oAckB), 32'd0);
    man_en = 1'b1;
    #1;
    chk("full_pop_no_ack", 32'(oAckB), 32'd0);
    @(negedge clk);
    man_en = 1'b0;
    #1;
    chk("full_after_pop_level", 32'(oLevel), 32'd7);
    chk("full_after_pop_flag", 32'(oFull), 32'd0);
    chk("full_after_pop_we", 32'(oWE), 32'd1);
    chk("full_reaccept", 32'(oAckB), 32'd1);
    exp_q.push_back({5'd8, 8'h48});
    @(negedge clk);
    iReqB = 1'b0;
    #1;
    chk("full_refill_level", 32'(oLevel), 32'd8);
    pulse_en(8);
    chk("full_drained", 32'(oEmpty), 32'd1);

    // Simultaneous enqueue and dequeue at level 3.
    for (int i = 1; i <= 3; i++) enq_a(5'(i), 8'(8'h60 + i), 1'b1);
    iReqA = 1'b1; iAddrA = 5'd4; iDataA = 8'h64;
    man_en = 1'b1;
    #1;
    chk("sim_ack", 32'(oAckA), 32'd1);
    exp_q.push_back({5'd4, 8'h64});
    @(negedge clk);
    man_en = 1'b0; iReqA = 1'b0;
    #1;
    chk("sim_level", 32'(oLevel), 32'd3);
    chk("sim_we", 32'(oWE), 32'd1);
    chk("sim_oldest", 32'({oAddr, oDataW}), 32'h0161);
    @(negedge clk);
    pulse_en(3);
    chk("sim_drained", 32'(oLevel), 32'd0);

    // Flush with an oWE pulse in flight.
    for (int i = 0; i < 5; i++) enq_a(5'(i + 1), 8'(8'h70 + i), i == 0);
    man_en = 1'b1;
    @(negedge clk);
    man_en = 1'b0; iFlush = 1'b1;
    iReqA = 1'b1; iAddrA = 5'h1F; iDataA = 8'hEE;
    #1;
    chk("flush_no_ack", 32'(oAckA), 32'd0);
    chk("flush_we_inflight", 32'(oWE), 32'd1);
    chk("flush_pre_level", 32'(oLevel), 32'd4);
    @(negedge clk);
    iFlush = 1'b0; iReqA = 1'b0;
    #1;
    chk("flush_level", 32'(oLevel), 32'd0);
    chk("flush_empty", 32'(oEmpty), 32'd1);
    chk("flush_we_done", 32'(oWE), 32'd0);
    base = wr_count;
    @(negedge clk);
    pulse_en(2);
    chk("flush_no_writes", 32'(wr_count), 32'(base));

    // Reset mid-stream while oWE is high.
    for (int i = 0; i < 5; i++) enq_b(5'(8'h10 + i), 8'(8'h80 + i), i == 0);
    man_en = 1'b1;
    @(negedge clk);
    man_en = 1'b0;
    #1;
    chk("midrst_we_before", 32'(oWE), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_we", 32'(oWE), 32'd0);
    chk("midrst_level", 32'(oLevel), 32'd0);
    chk("midrst_empty", 32'(oEmpty), 32'd1);
    chk("midrst_out", 32'({oAddr, oDataW}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    base = wr_count;
    @(negedge clk);
    pulse_en(3);
    chk("midrst_no_writes", 32'(wr_count), 32'(base));
    chk("midrst_level_after", 32'(oLevel), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
